axi_burst_initiator: RTL and testbench
======================================

Name: axi_burst_initiator

Overview:
- AXI4 manager that turns a simple command/stream interface into single-ID INCR bursts.
- Drives the slave port of an axi_dw_converter (or any AXI subordinate) from test engines, DMA front-ends and boot loaders.
- One transaction outstanding at a time; one completion status is returned per command.

Parameters:
AxiAddrWidth, 32, address width
AxiDataWidth, 64, data width (bits); strobe width AxiDataWidth/8
AxiIdWidth, 4, ID width
AxiId, 0, constant ID on AW/AR; B/R with any other ID flag a protocol error
axi_req_t, logic, AXI request struct type
axi_resp_t, logic, AXI response struct type

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  AxiAddrWidth  start address
cmd_len_i  in  8  AXI len (beats-1)
cmd_size_i  in  3  AXI size; must be <= log2(AxiDataWidth/8)
wdata_i  in  AxiDataWidth  write beat data
wstrb_i  in  AxiDataWidth/8  write beat strobe
wvalid_i  in  1  write beat valid
wready_o  out  1  write beat consumed
rdata_o  out  AxiDataWidth  read beat data
rlast_o  out  1  last read beat
rvalid_o  out  1  read beat valid
rready_i  in  1  read beat accepted
rsp_valid_o  out  1  completion valid
rsp_ready_i  in  1  completion accepted
rsp_resp_o  out  2  worst AXI resp of transaction
rsp_err_o  out  1  local/protocol error
mst_req_o  out  axi_req_t  AXI request
mst_resp_i  in  axi_resp_t  AXI response
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset (rst_i high at clk_i edge): FSM=IDLE. All valid outputs 0. cmd_ready_o=1 on the next cycle. rsp regs 0, busy_o=0.
- Reset mid-burst abandons the transaction. rst_i must only be asserted together with the subordinate's reset.
- States: IDLE, WR, WAIT_B, RD, RSP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd handshake, latch addr/len/size/write.
  - 4KB check: addr[11:0] + ((len+1)<<size) > 4096 → go to RSP with resp=2'b10, err=1, no bus traffic.
  - Illegal size (> log2(AxiDataWidth/8)) is handled the same way.
  - Otherwise go to WR or RD.
- AW/AR field values: burst=INCR, id=AxiId, lock/cache/prot/qos/region/atop/user=0.
- WR:
  - aw_valid=1 from the first WR cycle until the aw handshake; a sticky aw_done is then set.
  - W runs concurrently with AW (W before AW is allowed). w_valid=wvalid_i, wready_o=w_ready, w.data=wdata_i, w.strb=wstrb_i.
  - 8-bit beat counter; w.last=1 when counter==len.
  - Go to WAIT_B when last W has handshaken and aw_done is set (same-cycle completion of both included).
- WAIT_B:
  - b_ready=1.
  - On b handshake: resp=b.resp; err=1 if b.id != AxiId. Go to RSP.
- RD:
  - ar_valid until the ar handshake; then r_ready=rready_i.
  - rdata_o=r.data, rlast_o=r.last, rvalid_o=r_valid (only after the ar handshake). Zero-latency pass-through, no buffering.
  - Beat counter counts r handshakes.
  - Each beat updates resp: resp_acc = max(resp_acc, r.resp), with DECERR (3) > SLVERR (2) > EXOKAY/OKAY.
  - err is set if r.id != AxiId, if r.last arrives before counter==len, or if counter==len without r.last.
  - Leave on the r.last handshake → RSP.
- RSP:
  - rsp_valid_o=1 holding resp/err.
  - On rsp_ready_i go to IDLE; resp/err accumulators clear.
  - cmd_ready_o=0 until the IDLE cycle. No command overlap, so throughput is 1 transaction per (bus latency + 2) cycles minimum.
- Handshake rules:
  - Any asserted valid and its payload are held stable until ready.
  - cmd_ready_o never depends combinationally on cmd_valid_i.
- busy_o = (state != IDLE), registered.
- len=0: a single beat with w.last=1 on the first beat.
- len=255: counter must not wrap before last.

Test Plan:
- Write addr=0x1000, len=3, size=3, 4 beats 0x11..0x44, aw_ready delayed 5 cycles → W beats accepted before AW; w.last on the 4th beat only; b.resp=0 → rsp_resp_o=0, rsp_err_o=0.
- Read addr=0x2000, len=7, size=3; subordinate returns 8 beats with random r_valid gaps and rready_i toggling → rdata_o matches in order; rlast_o only on beat 8; rsp_resp_o=0.
- Read where beat 3 has r.resp=2 and beat 5 has r.resp=3 → rsp_resp_o=3, rsp_err_o=0.
- Write addr=0xFF8, len=1, size=3 (crosses 4KB) → no aw_valid ever; rsp_valid_o the cycle after the command; rsp_resp_o=2, rsp_err_o=1.
- Read len=3 with r.last on beat 2 → rsp_err_o=1. Separately, b.id=AxiId+1 on a write → rsp_err_o=1.
- Assert rst_i during the WR state after 2 beats → next cycle all valids=0, busy_o=0, cmd_ready_o=1; a fresh write then completes normally.

Source files
------------

// File: rtl/axi_burst_initiator.sv
// AXI4 manager: converts a command + write/read beat stream into single-ID INCR bursts,
// one transaction in flight, one completion status returned per command.
package axi_burst_initiator_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// Handshakes: every channel transfers on a cycle where valid && ready at the rising
// clock edge; a raised valid keeps itself and its payload stable until that transfer.
module axi_burst_initiator #(
    parameter int unsigned           AxiAddrWidth = 32,
    parameter int unsigned           AxiDataWidth = 64,
    parameter int unsigned           AxiIdWidth   = 4,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0,
    parameter type                   axi_req_t    = axi_burst_initiator_pkg::axi_req_t,
    parameter type                   axi_resp_t   = axi_burst_initiator_pkg::axi_resp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [2:0]                cmd_size_i,
    input  logic [AxiDataWidth-1:0]   wdata_i,
    input  logic [AxiDataWidth/8-1:0] wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic [AxiDataWidth-1:0]   rdata_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [1:0]                rsp_resp_o,
    output logic                      rsp_err_o,
    output axi_req_t                  mst_req_o,
    input  axi_resp_t                 mst_resp_i,
    output logic                      busy_o
);

    localparam logic [2:0] MaxSize = 3'($clog2(AxiDataWidth/8));

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, RSP} state_e;

    state_e                  state_q, state_d;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [7:0]              beat_q;
    logic                    aw_done_q, w_done_q, ar_done_q;
    logic [1:0]              resp_q;
    logic                    err_q;
    logic                    busy_q;

    logic        aw_valid, w_valid, ar_valid, b_ready, r_ready, beat_last;
    logic        cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        bad_cmd;
    logic [16:0] span_end;

    // End offset of the burst within its 4KB page; beyond 4096 the burst crosses.
    assign span_end = 17'(cmd_addr_i[11:0]) + ((17'(cmd_len_i) + 17'd1) << cmd_size_i);
    assign bad_cmd  = (cmd_size_i > MaxSize) || (span_end > 17'd4096);

    assign beat_last = (beat_q == len_q);
    assign aw_valid  = (state_q == WR) && !aw_done_q;
    assign w_valid   = (state_q == WR) && !w_done_q && wvalid_i;
    assign b_ready   = (state_q == WAIT_B);
    assign ar_valid  = (state_q == RD) && !ar_done_q;
    assign r_ready   = (state_q == RD) && ar_done_q && rready_i;

    assign cmd_hs = (state_q == IDLE) && cmd_valid_i;
    assign aw_hs  = aw_valid && mst_resp_i.aw_ready;
    assign w_hs   = w_valid && mst_resp_i.w_ready;
    assign b_hs   = b_ready && mst_resp_i.b_valid;
    assign ar_hs  = ar_valid && mst_resp_i.ar_ready;
    assign r_hs   = r_ready && mst_resp_i.r_valid;

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.id    = AxiId;
        mst_req_o.aw.addr  = addr_q;
        mst_req_o.aw.len   = len_q;
        mst_req_o.aw.size  = size_q;
        mst_req_o.aw.burst = 2'b01;
        mst_req_o.aw_valid = aw_valid;
        mst_req_o.w.data   = wdata_i;
        mst_req_o.w.strb   = wstrb_i;
        mst_req_o.w.last   = beat_last;
        mst_req_o.w_valid  = w_valid;
        mst_req_o.b_ready  = b_ready;
        mst_req_o.ar.id    = AxiId;
        mst_req_o.ar.addr  = addr_q;
        mst_req_o.ar.len   = len_q;
        mst_req_o.ar.size  = size_q;
        mst_req_o.ar.burst = 2'b01;
        mst_req_o.ar_valid = ar_valid;
        mst_req_o.r_ready  = r_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (cmd_valid_i) state_d = bad_cmd ? RSP : (cmd_write_i ? WR : RD);
            WR:     if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && beat_last))) state_d = WAIT_B;
            WAIT_B: if (b_hs) state_d = RSP;
            RD:     if (r_hs && mst_resp_i.r.last) state_d = RSP;
            RSP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            resp_q    <= 2'b00;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    beat_q    <= '0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    ar_done_q <= 1'b0;
                    if (cmd_hs) begin
                        addr_q <= cmd_addr_i;
                        len_q  <= cmd_len_i;
                        size_q <= cmd_size_i;
                        if (bad_cmd) begin
                            resp_q <= 2'b10;
                            err_q  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (beat_last) w_done_q <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (b_hs) begin
                        resp_q <= mst_resp_i.b.resp;
                        err_q  <= (mst_resp_i.b.id != AxiId);
                    end
                end
                RD: begin
                    if (ar_hs) ar_done_q <= 1'b1;
                    if (r_hs) begin
                        beat_q <= beat_q + 8'd1;
                        // Numeric max ranks DECERR over SLVERR over EXOKAY/OKAY.
                        if (mst_resp_i.r.resp > resp_q) resp_q <= mst_resp_i.r.resp;
                        if ((mst_resp_i.r.id != AxiId) || (mst_resp_i.r.last != beat_last))
                            err_q <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        resp_q <= 2'b00;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign wready_o    = (state_q == WR) && !w_done_q && mst_resp_i.w_ready;
    assign rdata_o     = mst_resp_i.r.data;
    assign rlast_o     = mst_resp_i.r.last;
    assign rvalid_o    = (state_q == RD) && ar_done_q && mst_resp_i.r_valid;
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_resp_o  = resp_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_axi_burst_initiator.sv
// Bench for axi_burst_initiator: directed commands, a reactive AXI subordinate, and a
// transaction-level model whose expected beats/responses are checked every cycle.
module tb_axi_burst_initiator;
    import axi_burst_initiator_pkg::*;

    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [7:0]  cmd_len_i = '0;
    logic [2:0]  cmd_size_i = '0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  wstrb_i = '0;
    logic        wvalid_i = 1'b0, rready_i = 1'b1, rsp_ready_i = 1'b1;
    logic        cmd_ready_o, wready_o, rlast_o, rvalid_o, rsp_valid_o, rsp_err_o, busy_o;
    logic [63:0] rdata_o;
    logic [1:0]  rsp_resp_o;
    axi_req_t    mst_req;
    axi_resp_t   mresp;

    always #5 clk = ~clk;

    axi_burst_initiator dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_size_i(cmd_size_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_resp_o(rsp_resp_o),
        .rsp_err_o(rsp_err_o), .mst_req_o(mst_req), .mst_resp_i(mresp), .busy_o(busy_o)
    );

    int total = 0;
    int bad_cnt = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ax_exp_t;

    ax_exp_t     exp_a_q[$];
    logic [72:0] exp_w_q[$];
    logic [64:0] exp_r_q[$];
    logic [2:0]  exp_rsp_q[$];

    logic [63:0] wd[256];
    logic [7:0]  ws[256];
    logic [63:0] rd_data[256];
    logic [1:0]  rd_resp[256];
    int          rd_last;
    logic [3:0]  rd_id = 4'h0;
    bit          rd_done;

    int          av_cnt = 0;
    int          w_hs_total = 0;
    int          w_at_aw = 0;
    logic [2:0]  last_rsp = 3'b111;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad_cnt++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic bit crosses(input logic [31:0] a, input int len, input int size);
        if (size > 3) return 1'b1;
        return (int'(a[11:0]) + (len + 1) * (1 << size)) > 4096;
    endfunction

    // Compare process: every cycle outside reset, check each handshake against the model.
    initial begin
        bit       aw_pend;
        aw_chan_t aw_prev;
        ax_exp_t  e;
        aw_pend = 1'b0;
        aw_prev = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                aw_pend = 1'b0;
            end else begin
                chk("ready_vs_busy", cmd_ready_o, !busy_o);
                if (mst_req.aw_valid || mst_req.ar_valid) av_cnt++;
                if (aw_pend) chk("aw_hold", {mst_req.aw_valid, mst_req.aw}, {1'b1, aw_prev});
                if (mst_req.aw_valid && mresp.aw_ready) begin
                    w_at_aw = w_hs_total;
                    if (exp_a_q.size() == 0) note_fail("aw_unexpected");
                    else begin
                        e = exp_a_q.pop_front();
                        chk("aw", {1'b1, mst_req.aw.addr, mst_req.aw.len, mst_req.aw.size,
                                   mst_req.aw.burst, mst_req.aw.id}, {e, 2'b01, 4'h0});
                    end
                end
                if (mst_req.ar_valid && mresp.ar_ready) begin
                    if (exp_a_q.size() == 0) note_fail("ar_unexpected");
                    else begin
                        e = exp_a_q.pop_front();
                        chk("ar", {1'b0, mst_req.ar.addr, mst_req.ar.len, mst_req.ar.size,
                                   mst_req.ar.burst, mst_req.ar.id}, {e, 2'b01, 4'h0});
                    end
                end
                if (mst_req.w_valid && mresp.w_ready) begin
                    w_hs_total++;
                    chk("wready", wready_o, 1'b1);
                    if (exp_w_q.size() == 0) note_fail("w_unexpected");
                    else chk("w_beat", {mst_req.w.data, mst_req.w.strb, mst_req.w.last},
                             exp_w_q.pop_front());
                end
                if (rvalid_o && rready_i) begin
                    if (exp_r_q.size() == 0) note_fail("r_unexpected");
                    else chk("r_beat", {rdata_o, rlast_o}, exp_r_q.pop_front());
                end
                if (rsp_valid_o && rsp_ready_i) begin
                    last_rsp = {rsp_resp_o, rsp_err_o};
                    if (exp_rsp_q.size() == 0) note_fail("rsp_unexpected");
                    else chk("rsp", {rsp_resp_o, rsp_err_o}, exp_rsp_q.pop_front());
                end
                aw_pend = mst_req.aw_valid && !mresp.aw_ready;
                aw_prev = mst_req.aw;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
        int n = 0;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
        cmd_len_i = len; cmd_size_i = size;
        do begin @(negedge clk); n++; end while (!cmd_ready_o && n < TMO);
        if (!cmd_ready_o) note_fail("cmd_timeout");
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drive_w(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            wvalid_i = 1'b1; wdata_i = wd[i]; wstrb_i = ws[i];
            do begin @(negedge clk); n++; end while (!wready_o && n < TMO);
            if (!wready_o) note_fail("w_timeout");
            @(posedge clk); #1;
        end
        wvalid_i = 1'b0;
    endtask

    task automatic wr_slave(input int aw_delay, input logic [1:0] br, input logic [3:0] bid);
        int n = 0;
        do begin @(negedge clk); n++; end while (!mst_req.aw_valid && n < TMO);
        if (!mst_req.aw_valid) note_fail("aw_timeout");
        repeat (aw_delay) @(posedge clk);
        #1 mresp.aw_ready = 1'b1;
        @(posedge clk); #1 mresp.aw_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!mst_req.b_ready && n < TMO);
        if (!mst_req.b_ready) note_fail("b_ready_timeout");
        @(posedge clk); #1;
        mresp.b_valid = 1'b1; mresp.b.resp = br; mresp.b.id = bid;
        @(negedge clk);
        @(posedge clk); #1 mresp.b_valid = 1'b0;
    endtask

    task automatic rd_slave(input bit gaps);
        int n = 0;
        do begin @(negedge clk); n++; end while (!mst_req.ar_valid && n < TMO);
        if (!mst_req.ar_valid) note_fail("ar_timeout");
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mresp.ar_ready = 1'b1;
        @(posedge clk); #1 mresp.ar_ready = 1'b0;
        for (int i = 0; i <= rd_last; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            mresp.r_valid = 1'b1; mresp.r.data = rd_data[i]; mresp.r.resp = rd_resp[i];
            mresp.r.last = (i == rd_last); mresp.r.id = rd_id;
            n = 0;
            do begin @(negedge clk); n++; end while (!mst_req.r_ready && n < TMO);
            if (!mst_req.r_ready) note_fail("r_timeout");
            @(posedge clk); #1;
            mresp.r_valid = 1'b0;
        end
        rd_done = 1'b1;
    endtask

    task automatic rready_drv();
        while (!rd_done) begin
            rready_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rready_i = 1'b1;
    endtask

    task automatic finish_txn(input bit bad, input int av0);
        int n = 0;
        if (bad) begin
            @(negedge clk);
            chk("rsp_next_cycle", {rsp_valid_o, busy_o}, 2'b11);
        end
        while (exp_rsp_q.size() != 0 && n < TMO) begin @(negedge clk); n++; end
        if (exp_rsp_q.size() != 0) begin
            note_fail("rsp_timeout");
            exp_rsp_q.delete();
        end
        if (bad) chk("no_bus_traffic", av_cnt - av0, 0);
        else chk("bus_traffic", av_cnt > av0, 1'b1);
        chk("queues_drained", {exp_a_q.size(), exp_w_q.size(), exp_r_q.size()}, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int aw_delay, input logic [1:0] br, input logic [3:0] bid);
        bit b;
        int av0;
        b = crosses(addr, int'(len), int'(size));
        av0 = av_cnt;
        if (b) exp_rsp_q.push_back(3'b101);
        else begin
            exp_a_q.push_back({1'b1, addr, len, size});
            for (int i = 0; i <= int'(len); i++) exp_w_q.push_back({wd[i], ws[i], i == int'(len)});
            exp_rsp_q.push_back({br, bid != 4'h0});
        end
        fork
            send_cmd(1'b1, addr, len, size);
            if (!b) drive_w(int'(len) + 1);
            if (!b) wr_slave(aw_delay, br, bid);
        join
        finish_txn(b, av0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input bit gaps, input bit toggle);
        bit         b;
        int         av0;
        logic [1:0] mx;
        b = crosses(addr, int'(len), int'(size));
        av0 = av_cnt;
        if (b) exp_rsp_q.push_back(3'b101);
        else begin
            exp_a_q.push_back({1'b0, addr, len, size});
            mx = 2'b00;
            for (int i = 0; i <= rd_last; i++) begin
                exp_r_q.push_back({rd_data[i], i == rd_last});
                if (rd_resp[i] > mx) mx = rd_resp[i];
            end
            exp_rsp_q.push_back({mx, (rd_id != 4'h0) || (rd_last != int'(len))});
        end
        rd_done = 1'b0;
        fork
            send_cmd(1'b0, addr, len, size);
            if (!b) rd_slave(gaps);
            if (!b && toggle) rready_drv();
        join
        finish_txn(b, av0);
    endtask

    task automatic set_read(input int last);
        for (int i = 0; i < 256; i++) begin
            rd_data[i] = 64'hFACE_0000_0000_0000 + 64'(i) * 64'h0001_0001_0003;
            rd_resp[i] = 2'b00;
        end
        rd_last = last;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        mresp = '0;
        mresp.w_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wd[i] = 64'h11 * 64'(i + 1);
            ws[i] = 8'hFF;
        end
        set_read(0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready_o, 1'b1);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                             mst_req.b_ready, rvalid_o, rsp_valid_o}, 6'b0);
        chk("reset_rsp_regs", {rsp_resp_o, rsp_err_o}, 3'b000);
        @(posedge clk); #1;

        // Write, AW held off so all four W beats go first.
        base = w_hs_total;
        do_write(32'h1000, 8'd3, 3'd3, 5, 2'b00, 4'h0);
        chk("w_before_aw", w_at_aw - base, 4);
        chk("t1_rsp_literal", last_rsp, 3'b000);

        // Read with gaps on R and rready_i toggling.
        set_read(7);
        do_read(32'h2000, 8'd7, 3'd3, 1'b1, 1'b1);
        chk("t2_rsp_literal", last_rsp, 3'b000);

        // Worst response wins: SLVERR on beat 3, DECERR on beat 5.
        set_read(7);
        rd_resp[2] = 2'b10;
        rd_resp[4] = 2'b11;
        do_read(32'h2100, 8'd7, 3'd3, 1'b0, 1'b0);
        chk("t3_rsp_literal", last_rsp, 3'b110);

        // 4KB crossing and illegal size are refused without bus traffic.
        chk("model_cross", crosses(32'hFF8, 1, 3), 1'b1);
        do_write(32'h0000_0FF8, 8'd1, 3'd3, 1, 2'b00, 4'h0);
        chk("t4_rsp_literal", last_rsp, 3'b101);
        do_read(32'h0, 8'd0, 3'd4, 1'b0, 1'b0);
        chk("size_rsp_literal", last_rsp, 3'b101);

        // Exactly filling a page is legal.
        chk("model_fit", crosses(32'hF80, 15, 3), 1'b0);
        set_read(15);
        do_read(32'h0000_0F80, 8'd15, 3'd3, 1'b0, 1'b1);
        chk("fit_rsp_literal", last_rsp, 3'b000);

        // Early r.last, then a B with the wrong ID.
        set_read(1);
        do_read(32'h3000, 8'd3, 3'd3, 1'b1, 1'b0);
        chk("early_last_literal", last_rsp, 3'b001);
        do_write(32'h4000, 8'd0, 3'd2, 1, 2'b00, 4'h1);
        chk("bad_bid_literal", last_rsp, 3'b001);

        // Longest burst: the beat counter must reach 255 without wrapping.
        set_read(255);
        do_read(32'h0, 8'd255, 3'd3, 1'b0, 1'b0);
        chk("len255_rsp_literal", last_rsp, 3'b000);

        // Reset after two W beats of a four-beat write.
        for (int i = 0; i < 2; i++) exp_w_q.push_back({wd[i], ws[i], 1'b0});
        exp_a_q.push_back({1'b1, 32'h5000, 8'd3, 3'd3});
        fork
            send_cmd(1'b1, 32'h5000, 8'd3, 3'd3);
            drive_w(2);
        join
        rst_i = 1'b1;
        wvalid_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid, mst_req.b_ready,
                              mst_req.r_ready, rvalid_o, rsp_valid_o, wready_o}, 8'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_cmd_ready", cmd_ready_o, 1'b1);
        chk("midrst_w_drained", exp_w_q.size(), 0);
        exp_a_q.delete();
        @(posedge clk); #1 wvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        do_write(32'h5000, 8'd2, 3'd3, 1, 2'b01, 4'h0);
        chk("after_rst_literal", last_rsp, 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
